// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the sequential shift-and-add
// multiplier (mul_seq_ctrl and its combinational step, mul_seq_step).
//   state_t    : controller states IDLE / BUSY / DONE (2-bit encoding)
//   MUL_SEQ_W  : default operand width
//   cnt_w()    : width of the step counter, wide enough to hold 0..W
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_SEQ_W = 4;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: operand/result handshake bundle for mul_seq_ctrl.
//   in_valid/in_ready/a/b        : operand pair from the producer
//   out_valid/out_ready/product  : 2W-bit result to the consumer
//   busy                         : controller is stepping the multiply
// Modports: master = producer/consumer side, slave = the controller.
interface mul_seq_ctrl_if
    import mul_seq_pkg::*;
#(
    parameter int W = MUL_SEQ_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/mul_seq_step.sv
// mul_seq_step: one shift-and-add iteration, purely combinational.
//   mcand    : multiplicand (W bits)
//   prod_in  : current {accumulator, remaining multiplier bits} (2W bits)
//   prod_out : value after adding the partial-product row and shifting right
// The partial-product row is mcand gated by the current multiplier LSB
// (prod_in[0]). The adder is W+1 bits wide so its carry lands in the MSB of
// prod_out instead of being lost.
module mul_seq_step
    import mul_seq_pkg::*;
#(
    parameter int W = MUL_SEQ_W
) (
    input  logic [W-1:0]   mcand,
    input  logic [2*W-1:0] prod_in,
    output logic [2*W-1:0] prod_out
);

    logic [W-1:0] pp_row;
    logic [W:0]   sum;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pp
            assign pp_row[gi] = mcand[gi] & prod_in[0];
        end
    endgenerate

    assign sum      = {1'b0, prod_in[2*W-1:W]} + {1'b0, pp_row};
    // {carry, sum} becomes the new upper half; the consumed multiplier bit
    // falls off the bottom.
    assign prod_out = {sum, prod_in[W-1:1]};

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-and-add multiplier controller.
// Accepts an unsigned W x W operand pair over a valid/ready handshake, runs
// one adder step per cycle for W cycles, then presents the 2W-bit product
// until the consumer takes it.
//   clk    : clock, rising edge
//   rst    : synchronous reset, active-high
//   bus    : mul_seq_ctrl_if.slave (in_valid/in_ready/a/b,
//            out_valid/out_ready/product, busy)
// Optional build macro MUL_SEQ_ZERO_BYPASS_EN: a zero operand skips the
// BUSY phase and goes directly to DONE with product 0.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W = MUL_SEQ_W
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);

    localparam int            CW       = cnt_w(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [2*W-1:0]   step_prod;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, busy_q, out_valid_q;

    mul_seq_step #(
        .W (W)
    ) u_step (
        .mcand    (mcand_q),
        .prod_in  (prod_q),
        .prod_out (step_prod)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.a;
                    prod_d  = {{W{1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if (bus.a == '0 || bus.b == '0) begin
                        prod_d  = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // prod is left untouched so product shows the last result
                // until the next acceptance.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            // Handshake outputs are registered copies of the next-state
            // decode, so they always equal a decode of state_q.
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d == BUSY);
            out_valid_q <= (state_d == DONE);

            if (state_q == BUSY) begin
                assert (cnt_q <= CNT_LAST);
            end
`ifndef MUL_SEQ_ZERO_BYPASS_EN
            // Without the bypass, DONE is only reachable from the last BUSY step.
            if (state_q == IDLE) begin
                assert (state_d != DONE);
            end
`endif
            if (state_q == BUSY && state_d == DONE) begin
                assert (cnt_q == CNT_LAST);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = prod_q;

endmodule
